// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receive front end: synchronises the raw lines, deframes and
// checks 11-bit frames, and queues good scan-code bytes in a small FIFO.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       sampling,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    // clk_sync: [0] first stage, [1] synchronised level, [2] history
    logic [2:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    state_e        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];

    logic       sample;
    logic       din;
    logic       push_req;
    logic [7:0] push_byte;
    logic       full;
    logic       pop;
    logic       push;

    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        sample     = clk_sync_q[2] & ~clk_sync_q[1];
        din        = dat_sync_q[1];
    end

    // The start bit is shifted in too, so at the stop-bit sample shift_q
    // holds {parity, data[7:0], start} and din carries the stop bit.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        tmo_d       = tmo_q;
        frame_err_d = 1'b0;
        push_req    = 1'b0;
        push_byte   = shift_q[8:1];
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (sample && !din) begin
                    state_d  = RECV;
                    bitcnt_d = 4'd1;
                    shift_d  = {din, shift_q[9:1]};
                end
            end
            RECV: begin
                if (sample) begin
                    tmo_d = '0;
                    if (bitcnt_q == 4'd10) begin
                        state_d  = IDLE;
                        bitcnt_d = 4'd0;
                        if (!shift_q[0] && din && (^shift_q[9:1])) begin
                            push_req = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        shift_d  = {din, shift_q[9:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else if (tmo_q >= TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = IDLE;
                    bitcnt_d    = 4'd0;
                    tmo_d       = '0;
                    frame_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                bitcnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        ready = (rd_ptr_q != wr_ptr_q);
        pop   = !nextdata_n && ready;
        // At full, a same-cycle pop frees the slot being written.
        push  = push_req && (!full || pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_byte;
        end
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

        overflow_d = overflow_q;
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end else if (pop) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= 3'b111;
            dat_sync_q  <= 2'b11;
            state_q     <= IDLE;
            bitcnt_q    <= 4'd0;
            shift_q     <= '0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign data      = mem_q[rd_ptr_q[AW-1:0]];
    assign sampling  = sample;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames and checks the FIFO
// output against a queue of expected scan-code bytes.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int HALF  = 4;

    logic       clk        = 1'b0;
    logic       clrn       = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       sampling;
    logic       frame_err;

    ps2_rx_fifo #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata_n(nextdata_n),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .sampling  (sampling),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_pass     = 0;
    int n_fail     = 0;
    int samp_total = 0;
    int fe_total   = 0;
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        if (sampling === 1'b1) samp_total++;
        if (frame_err === 1'b1) fe_total++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        logic p;
        p = (~^b) ^ bad_par;
        return {stop, p, b, 1'b0};
    endfunction

    // Sends bits[0..nbits-1]; captures the outputs around the last sample pulse.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_commit,
                             output int pulses, output logic rdy_before, output logic rdy_after,
                             output logic fe_after, output logic [7:0] data_after);
        bit captured;
        int j;
        logic [7:0] e;
        pulses     = 0;
        rdy_before = 1'bx;
        rdy_after  = 1'bx;
        fe_after   = 1'bx;
        data_after = 8'hxx;
        captured   = 0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            j = 0;
            while (j < HALF) begin
                @(negedge clk);
                j++;
                if (sampling === 1'b1) begin
                    pulses++;
                    if (i == nbits - 1 && !captured) begin
                        captured   = 1;
                        rdy_before = ready;
                        if (pop_at_commit) begin
                            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                            check("commit_pop_data", data, e);
                            nextdata_n = 1'b0;
                        end
                        @(negedge clk);
                        j++;
                        nextdata_n = 1'b1;
                        if (sampling === 1'b1) pulses++;
                        rdy_after  = ready;
                        fe_after   = frame_err;
                        data_after = data;
                    end
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, "_ready"}, ready, 1);
        check({tag, "_data"}, data, e);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
    endtask

    initial begin
        int pulses;
        int s0;
        int f0;
        logic rb;
        logic ra;
        logic fa;
        logic [7:0] da;
        logic exp_ovf;

        // reset with inputs toggling
        repeat (8) begin
            @(negedge clk);
            ps2_clk    = ~ps2_clk;
            ps2_data   = 1'($urandom_range(0, 1));
            nextdata_n = 1'($urandom_range(0, 1));
        end
        check("rst_data", data, 8'h00);
        check("rst_ready", ready, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sampling", sampling, 0);
        check("rst_frame_err", frame_err, 0);
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        @(negedge clk);
        clrn = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_ready", ready, 0);
        check("post_rst_pulses", samp_total, 0);
        check("post_rst_frame_err", fe_total, 0);

        // single byte
        s0 = samp_total;
        f0 = fe_total;
        send_bits(mk_frame(8'h1C, 0, 1), 11, 0, pulses, rb, ra, fa, da);
        exp_q.push_back(8'h1C);
        check("single_pulses", pulses, 11);
        check("single_pulse_total", samp_total - s0, 11);
        check("single_ready_before", rb, 0);
        check("single_ready_after", ra, 1);
        check("single_data_after", da, 8'h1C);
        check("single_no_err", fe_total - f0, 0);
        pop_one("single_pop");
        check("single_empty", ready, 0);

        // bad parity
        f0 = fe_total;
        send_bits(mk_frame(8'h1C, 1, 1), 11, 0, pulses, rb, ra, fa, da);
        check("parity_err_pulse", fa, 1);
        check("parity_err_count", fe_total - f0, 1);
        check("parity_ready", ready, 0);

        // bad stop
        f0 = fe_total;
        send_bits(mk_frame(8'h1C, 0, 0), 11, 0, pulses, rb, ra, fa, da);
        check("stop_err_pulse", fa, 1);
        check("stop_err_count", fe_total - f0, 1);
        check("stop_ready", ready, 0);

        // timeout after a 5-bit partial frame
        f0 = fe_total;
        send_bits(mk_frame(8'h55, 0, 1), 5, 0, pulses, rb, ra, fa, da);
        repeat (TMO - 20) @(negedge clk);
        check("timeout_not_early", fe_total - f0, 0);
        repeat (40) @(negedge clk);
        check("timeout_err_count", fe_total - f0, 1);
        check("timeout_ready", ready, 0);
        f0 = fe_total;
        send_bits(mk_frame(8'hF0, 0, 1), 11, 0, pulses, rb, ra, fa, da);
        exp_q.push_back(8'hF0);
        check("after_timeout_ready", ra, 1);
        check("after_timeout_data", da, 8'hF0);
        check("after_timeout_no_err", fe_total - f0, 0);
        pop_one("after_timeout_pop");
        check("after_timeout_empty", ready, 0);

        // overflow: 9 frames, no pops
        exp_ovf = 1'b0;
        for (int v = 1; v <= 9; v++) begin
            send_bits(mk_frame(8'(v), 0, 1), 11, 0, pulses, rb, ra, fa, da);
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(v));
            else exp_ovf = 1'b1;
            check("ovf_flag", overflow, exp_ovf);
        end
        for (int i = 0; i < DEPTH; i++) begin
            pop_one("ovf_pop");
            if (i == 0) check("ovf_clear_on_pop", overflow, 0);
        end
        check("ovf_drained", ready, 0);

        // pop in the cycle the 9th frame commits into a full FIFO
        for (int v = 1; v <= 8; v++) begin
            send_bits(mk_frame(8'(v), 0, 1), 11, 0, pulses, rb, ra, fa, da);
            exp_q.push_back(8'(v));
        end
        check("full_no_ovf", overflow, 0);
        send_bits(mk_frame(8'h09, 0, 1), 11, 1, pulses, rb, ra, fa, da);
        exp_q.push_back(8'h09);
        check("simul_ready", ra, 1);
        check("simul_head", da, 8'h02);
        check("simul_no_ovf", overflow, 0);
        for (int i = 0; i < DEPTH; i++) begin
            pop_one("simul_pop");
        end
        check("simul_drained", ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 keyboard receive front end. It samples the raw `ps2_clk`/`ps2_data` lines, deframes 11-bit PS/2 frames and checks start, stop and odd parity. Valid scan-code bytes are pushed into a small FIFO. It feeds the scan-code display/counter stage, which reads one byte per `nextdata_n` low pulse whenever `ready` is high.

## Interface
- `FIFO_DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, default 50000: max `clk` cycles between sampled bits inside a frame before abort.
- `clk`  in  1: system clock; everything is on its rising edge.
- `clrn`  in  1: reset. Asynchronous, active-low.
- `ps2_clk`  in  1: raw PS/2 clock, asynchronous.
- `ps2_data`  in  1: raw PS/2 data, asynchronous.
- `nextdata_n`  in  1: active-low pop request, one pop per low cycle.
- `data`  out  8: byte at the FIFO head.
- `ready`  out  1: FIFO non-empty.
- `overflow`  out  1: sticky; a valid frame was dropped because the FIFO was full.
- `sampling`  out  1: one-cycle pulse per detected `ps2_clk` falling edge.
- `frame_err`  out  1: one-cycle pulse when a frame is rejected (parity, start, stop or timeout).

## Operation
- **Synchronisers:** `ps2_clk` goes through a 3-FF chain (2 sync + 1 history). `ps2_data` goes through a 2-FF chain.
- **Edge detect:** a falling edge is history=1 and sync=0. That cycle is a sample cycle, and `sampling`=1 for that cycle.
- **FSM states:** IDLE and RECV, plus a 4-bit bit counter `bitcnt` and a 10-bit shift register.
  - **IDLE:** a sample with data=0 (start bit) moves to RECV with `bitcnt`=1. A sample with data=1 is ignored and the FSM stays in IDLE.
  - **RECV:** each sample shifts the data bit in and increments `bitcnt`. Bits 1–8 are data (LSB first), bit 9 is parity, bit 10 is stop.
  - **End of frame:** on the sample where `bitcnt`=10 the frame is evaluated and the FSM returns to IDLE.
- **Frame valid:** the XOR of the 8 data bits and the parity bit is 1 (odd parity) and stop=1. A valid frame is pushed. An invalid frame pulses `frame_err` and nothing is pushed.
- **Timeout:** a cycle counter clears on every sample and runs only in RECV. When it reaches `TIMEOUT_CYCLES` the FSM returns to IDLE, discards the partial frame and pulses `frame_err`.
- **FIFO structure:** register array with read and write pointers of width log2(`FIFO_DEPTH`)+1. The extra MSB distinguishes full from empty.
  - `data` = mem[rd_ptr], read combinationally from the registered array.
  - `ready` = (rd_ptr != wr_ptr).
- **Pop:** when `nextdata_n`=0 and `ready`=1, rd_ptr increments. A pop while empty is ignored.
- **Push:** happens on valid-frame commit.
  - If not full, the byte is written and wr_ptr increments.
  - If full and a pop occurs in the same cycle, the push is still accepted (occupancy unchanged).
  - If full with no pop, the byte is dropped and `overflow` is set.
- **Overflow clear:** `overflow` clears on any accepted pop. A set (drop) in the same cycle as a clear resolves to set.
- **Pointer wrap:** pointers wrap naturally modulo 2·`FIFO_DEPTH`.

## Timing
- **Reset (async, `clrn`=0):** state=IDLE, `bitcnt`=0, pointers=0, mem=0, synchronisers=1.
  - Outputs: `data`=0x00, `ready`=0, `overflow`=0, `sampling`=0, `frame_err`=0.
- **Reset mid-frame:** the partial frame is lost. After release, reception resumes at the next start bit.
- **Edge latency:** a `ps2_clk` fall captured at edge k gives `sampling`=1 in the cycle after edge k+1, for exactly one cycle. Data is sampled from the data synchroniser in that same cycle.
- **Push latency:** `ready` and `data` update on the clock edge that ends the stop-bit sample cycle, i.e. 1 cycle after that `sampling` pulse.
- **Pop latency:** a pop at edge e exposes the next entry (or `ready`=0) immediately after e. Holding `nextdata_n` low for N cycles pops up to N entries.
- **`frame_err` timing:** asserted in the cycle after the stop-bit sample, or in the cycle after the timeout count is reached.
- **Input constraint:** `ps2_clk` low/high phases are ≥3 `clk` cycles. Shorter pulses need not be detected.

## Test plan
- **Reset:** hold `clrn` low, toggle inputs → all outputs 0. Release → `ready`=0 and no pulses until a frame arrives.
- **Single byte:** send frame 0x1C (parity 0, stop 1) → exactly 11 `sampling` pulses. `ready`=1 and `data`=0x1C one cycle after the 11th pulse. One-cycle `nextdata_n`=0 → `ready`=0.
- **Bad frames:** send 0x1C with parity 1 → `frame_err` pulse and `ready` stays 0. Send 0x1C with stop=0 → same result.
- **Timeout:** send 5 bits then idle for `TIMEOUT_CYCLES` → `frame_err` pulse and FSM in IDLE. A following valid 0xF0 frame is received correctly.
- **Overflow:** push 9 frames 0x01..0x09 with no pops at depth 8 → `overflow`=1 after the 9th. Pops return 0x01..0x08, and `overflow` clears on the first pop.
- **Simultaneous push/pop at full:** with the FIFO full, pulse `nextdata_n` low in the cycle the 9th frame commits → `overflow` stays 0 and occupancy stays 8. Pops return 0x02..0x09.
